scan_chain_seq: RTL and testbench

- Sequencer for a single scan chain built from gf180mcu_fd_sc_mcu9t5v0__sdffq cells.
- Drives the chain's SE and SI, and the enable of the chain's clock gate.
- Consumes a stream of pattern beats and runs overlapped load/unload shifts with one capture cycle between patterns.
- Compares the chain's scan-out bit by bit against masked expected data and reports a saturating mismatch count.

---
 rtl/scan_chain_seq_pkg.sv | 34 +++
 rtl/scan_err_cnt.sv | 80 ++++++++
 rtl/scan_chain_seq.sv | 189 ++++++++++++++++++
 tb/tb_scan_chain_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_seq_pkg.sv
// rtl/scan_chain_seq_pkg.sv - shared types and helpers for the scan chain sequencer
//
// Purpose: sequencer state encoding and the bit-counter width helper.
// Ports:   none (package).

package scan_chain_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    FINISH
  } state_e;

  // Width of a counter that must hold 0..n-1.
  // The result is never smaller than 1, so a 1-flop chain still gets a legal vector.
  function automatic int clog2(input int n);
    int w;
    int v;
    w = 0;
    v = n - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_err_cnt.sv
// rtl/scan_err_cnt.sv - registered scan-out compare with saturating mismatch counter
//
// Purpose: holds the expected bit, mask and compare-enable that belong to the
//          bit currently being shifted, compares them against the chain's
//          scan-out, and counts mismatches without wrapping.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   load_i        a pattern beat was accepted; capture exp/mask/cmp_en
//   exp_i         expected scan-out bit for the accepted beat
//   mask_i        1 = ignore this bit
//   cmp_en_i      0 while the chain holds no valid response (first load)
//   clear_i       zero the counter (new sequence)
//   active_i      the chain is shifting this cycle (CHAIN_CE && SE)
//   so_i          chain scan-out
//   err_cnt_o     saturating mismatch count

module scan_err_cnt
  import scan_chain_seq_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             exp_i,
  input  logic             mask_i,
  input  logic             cmp_en_i,
  input  logic             clear_i,
  input  logic             active_i,
  input  logic             so_i,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic             exp_q, exp_d;
  logic             mask_q, mask_d;
  logic             cmp_en_q, cmp_en_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             inc;

  // The compare qualifiers are registered alongside SI, so they line up with
  // the cycle in which that bit is actually shifted through the chain.
  always_comb begin
    exp_d    = exp_q;
    mask_d   = mask_q;
    cmp_en_d = cmp_en_q;
    if (load_i) begin
      exp_d    = exp_i;
      mask_d   = mask_i;
      cmp_en_d = cmp_en_i;
    end
  end

  assign inc = active_i && cmp_en_q && !mask_q && (so_i != exp_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_q    <= 1'b0;
      mask_q   <= 1'b0;
      cmp_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      exp_q    <= exp_d;
      mask_q   <= mask_d;
      cmp_en_q <= cmp_en_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/scan_chain_seq.sv
// rtl/scan_chain_seq.sv - load/capture/unload sequencer for one sdffq scan chain
//
// Purpose: consumes pattern beats, drives SE/SI/CHAIN_CE of a single scan
//          chain with overlapped load/unload and one capture cycle between
//          patterns, and reports the masked scan-out mismatch count.
// Ports:
//   CLK, RST        clock (shared with the chain), async active-high reset
//   START, NUM_PAT  start request and pattern count (latched on accept)
//   PAT_VALID/READY beat handshake; PAT_SI load bit, PAT_EXP expected unload
//                   bit, PAT_MASK 1 = do not compare
//   SO              chain scan-out
//   SE, SI          chain scan enable / scan-in
//   CHAIN_CE        chain clock-gate enable
//   BUSY, DONE      sequence in progress / one-cycle completion pulse
//   ERR_CNT, FAIL   saturating mismatch count / count is non-zero

module scan_chain_seq
  import scan_chain_seq_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int PAT_W     = 16,
  parameter int ERR_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [PAT_W-1:0] NUM_PAT,
  input  logic             PAT_VALID,
  output logic             PAT_READY,
  input  logic             PAT_SI,
  input  logic             PAT_EXP,
  input  logic             PAT_MASK,
  input  logic             SO,
  output logic             SE,
  output logic             SI,
  output logic             CHAIN_CE,
  output logic             BUSY,
  output logic             DONE,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL
);

  localparam int            CW       = clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] num_q, num_d;
  logic             se_q, se_d;
  logic             si_q, si_d;
  logic             ce_q, ce_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_bit;
  logic             clear;
  logic             cmp_en;

  assign accept   = PAT_VALID && ready_q;
  assign last_bit = (bit_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    pat_d   = pat_q;
    num_d   = num_q;
    se_d    = se_q;
    si_d    = si_q;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    clear   = 1'b0;
    cmp_en  = 1'b1;

    // An accepted beat becomes one shift at the chain in the next cycle.
    // Without a beat the clock gate closes and SE/SI simply hold.
    if (accept) begin
      se_d  = 1'b1;
      si_d  = PAT_SI;
      ce_d  = 1'b1;
      bit_d = last_bit ? '0 : bit_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          clear = 1'b1;
          if (NUM_PAT != '0) begin
            num_d   = NUM_PAT;
            pat_d   = '0;
            bit_d   = '0;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        // Until the first pattern is fully loaded the chain holds nothing
        // worth comparing.
        cmp_en = (pat_q != '0);
        if (accept && last_bit) begin
          pat_d   = pat_q + 1'b1;
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // Capture pulse lands directly behind the last shift of the load.
        se_d    = 1'b0;
        ce_d    = 1'b1;
        state_d = (pat_q < num_q) ? SHIFT : UNLOAD;
      end

      UNLOAD: begin
        if (accept && last_bit) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // The last unload bit is compared in this cycle; the count is final
        // when DONE is seen.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == SHIFT) || (state_d == UNLOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= '0;
      pat_q   <= '0;
      num_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      ce_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pat_q   <= pat_d;
      num_q   <= num_d;
      se_q    <= se_d;
      si_q    <= si_d;
      ce_q    <= ce_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  scan_err_cnt #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (accept),
    .exp_i     (PAT_EXP),
    .mask_i    (PAT_MASK),
    .cmp_en_i  (cmp_en),
    .clear_i   (clear),
    .active_i  (ce_q && se_q),
    .so_i      (SO),
    .err_cnt_o (ERR_CNT)
  );

  assign PAT_READY = ready_q;
  assign SE        = se_q;
  assign SI        = si_q;
  assign CHAIN_CE  = ce_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FAIL      = (ERR_CNT != '0);

endmodule

// File: tb/tb_scan_chain_seq.sv
// tb/tb_scan_chain_seq.sv - scoreboard bench for scan_chain_seq with a behavioural sdffq chain

module tb_scan_chain_seq;

  localparam int L = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] NUM_PAT = '0;
  logic        PAT_VALID = 1'b0;
  logic        PAT_SI = 1'b0;
  logic        PAT_EXP = 1'b0;
  logic        PAT_MASK = 1'b0;
  logic        SO;
  logic        PAT_READY, SE, SI, CHAIN_CE, BUSY, DONE, FAIL;
  logic [15:0] ERR_CNT;
  logic        ready2, se2, si2, ce2, busy2, done2, fail2;
  logic [1:0]  err2;

  always #5 CLK = ~CLK;

  scan_chain_seq #(.CHAIN_LEN(L), .PAT_W(16), .ERR_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .NUM_PAT(NUM_PAT),
    .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY), .PAT_SI(PAT_SI),
    .PAT_EXP(PAT_EXP), .PAT_MASK(PAT_MASK), .SO(SO), .SE(SE), .SI(SI),
    .CHAIN_CE(CHAIN_CE), .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT), .FAIL(FAIL)
  );

  scan_chain_seq #(.CHAIN_LEN(L), .PAT_W(16), .ERR_W(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .START(START), .NUM_PAT(NUM_PAT),
    .PAT_VALID(PAT_VALID), .PAT_READY(ready2), .PAT_SI(PAT_SI),
    .PAT_EXP(PAT_EXP), .PAT_MASK(PAT_MASK), .SO(SO), .SE(se2), .SI(si2),
    .CHAIN_CE(ce2), .BUSY(busy2), .DONE(done2), .ERR_CNT(err2), .FAIL(fail2)
  );

  // Behavioural chain of L sdffq flops, functional D = ~Q, clock gated by CHAIN_CE.
  logic [L-1:0] chain_q = '0;
  always @(posedge CLK) if (CHAIN_CE) chain_q <= SE ? {chain_q[L-2:0], SI} : ~chain_q;
  assign SO = chain_q[L-1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus tables for one sequence.
  bit si_a [0:63];
  bit exp_a [0:63];
  bit mask_a [0:63];
  int total;

  // Response of the chain: a capture inverts every flop and the unload shifts
  // bits out in load order, so unload beat k must equal ~load bit k of the
  // previous pattern. The first load's compares never count.
  function automatic int count_errs(input int tot);
    int c;
    c = 0;
    for (int b = L; b < tot; b++)
      if (!mask_a[b] && (exp_a[b] == si_a[b-L])) c++;
    return c;
  endfunction

  task automatic gen(input int n, input bit first_inv);
    total = (n + 1) * L;
    for (int b = 0; b < total; b++) begin
      si_a[b]   = 1'($urandom_range(0, 1));
      mask_a[b] = 1'b0;
      if (b < L) exp_a[b] = first_inv ? ~chain_q[L-1-b] : chain_q[L-1-b];
      else       exp_a[b] = ~si_a[b-L];
    end
  endtask

  typedef struct { int e16; int e2; } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input int c);
    exp_t e;
    e.e16 = (c > 65535) ? 65535 : c;
    e.e2  = (c > 3) ? 3 : c;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: every DONE consumes one expected result.
  always @(negedge CLK) begin : sb_mon
    exp_t e;
    if (DONE) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: DONE seen with no sequence outstanding");
      end else begin
        e = sb_q.pop_front();
        chk("err_cnt", ERR_CNT, e.e16);
        chk("fail_flag", FAIL, e.e16 != 0);
        chk("err_cnt_w2", err2, e.e2);
        chk("fail_flag_w2", fail2, e.e2 != 0);
        chk("w2_ctrl_at_done", {ready2, ce2, busy2, done2}, 4'b0001);
      end
    end
  end

  // Cycle monitor: beat count, CHAIN_CE run length, per-beat and bubble behaviour.
  int   beats = 0;
  int   ce_run = 0, ce_se0 = 0, last_run = 0, last_se0 = 0;
  bit   bub_chk = 0;
  logic p_ready = 0, p_valid = 0, p_se = 0, p_ce = 0, p_busy = 0, p_si = 0;
  logic [15:0] p_err = '0;

  always @(negedge CLK) begin
    if (PAT_READY && PAT_VALID) beats++;
    if (CHAIN_CE) begin
      ce_run++;
      if (!SE) ce_se0++;
    end else if (ce_run > 0) begin
      last_run = ce_run;
      last_se0 = ce_se0;
      ce_run = 0;
      ce_se0 = 0;
    end
    if (p_ready && p_valid) chk("beat_shift", {CHAIN_CE, SE, SI}, {2'b11, p_si});
    if (bub_chk) begin
      if (p_ready && !p_valid) begin
        chk("bubble_ce", CHAIN_CE, 0);
        chk("bubble_se_hold", SE, p_se);
      end
      if (p_busy && !p_ce) chk("bubble_err_hold", ERR_CNT, p_err);
    end
    p_ready = PAT_READY; p_valid = PAT_VALID; p_se = SE; p_ce = CHAIN_CE;
    p_busy = BUSY; p_err = ERR_CNT; p_si = PAT_SI;
  end

  // Runs one sequence from the current tables. abort_at >= 0 stops after that
  // many beats with no DONE expected; busy_start_at pulses START mid-run.
  task automatic run(input int n, input bit bubbles, input int abort_at, input int busy_start_at);
    int idx;
    int cyc;
    if (abort_at < 0) push_exp(count_errs(total));
    @(posedge CLK); #1;
    START = 1'b1;
    NUM_PAT = 16'(n);
    @(posedge CLK); #1;
    START = 1'b0;
    beats = 0;
    idx = 0;
    cyc = 0;
    while (idx < total && (abort_at < 0 || idx < abort_at)) begin
      PAT_VALID = !(bubbles && (cyc % 3 == 2));
      PAT_SI    = si_a[idx];
      PAT_EXP   = exp_a[idx];
      PAT_MASK  = mask_a[idx];
      START     = (cyc == busy_start_at);
      if (cyc == busy_start_at) NUM_PAT = 16'd3;
      @(negedge CLK);
      if (PAT_READY && PAT_VALID) idx++;
      @(posedge CLK); #1;
      cyc++;
      if (cyc > 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_timeout: accepted %0d of %0d beats", idx, total);
        break;
      end
    end
    PAT_VALID = 1'b0;
    START = 1'b0;
    if (abort_at < 0) begin
      @(negedge CLK);
      chk("done_early", DONE, 0);
      @(posedge CLK);
      @(negedge CLK);
      chk("done_latency", DONE, 1);
      @(posedge CLK); #1;
      chk("beats_accepted", beats, total);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int base;
    bit last_si;
    bit seen;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", {SE, SI, CHAIN_CE, PAT_READY, BUSY, DONE, FAIL}, 0);
    chk("reset_err_cnt", ERR_CNT, 0);
    RST = 1'b0;

    // Reset in the middle of the first load, then a clean NUM_PAT=1 run.
    gen(1, 1'b0);
    run(1, 1'b0, 5, -1);
    @(negedge CLK); #2;
    RST = 1'b1;
    #1;
    chk("midshift_reset_outputs", {SE, SI, CHAIN_CE, PAT_READY, BUSY, DONE}, 0);
    chk("midshift_reset_err", ERR_CNT, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    gen(1, 1'b0);
    run(1, 1'b0, -1, -1);

    // PAT_VALID tied high, NUM_PAT=2, all expectations correct.
    gen(2, 1'b0);
    run(2, 1'b0, -1, -1);
    chk("ce_run_len", last_run, 26);
    chk("ce_capture_cycles", last_se0, 2);

    // First-load expectations all wrong: must not be counted.
    gen(2, 1'b1);
    run(2, 1'b0, -1, -1);

    // Three flipped bits in the final unload, one of them masked.
    gen(2, 1'b0);
    base = $urandom_range(0, L - 1);
    exp_a[2*L + base]           = ~exp_a[2*L + base];
    exp_a[2*L + (base + 3) % L] = ~exp_a[2*L + (base + 3) % L];
    exp_a[2*L + (base + 5) % L] = ~exp_a[2*L + (base + 5) % L];
    mask_a[2*L + base]          = 1'b1;
    chk("model_flip_count", count_errs(total), 2);
    run(2, 1'b0, -1, -1);

    // Same patterns with a bubble every third cycle.
    bub_chk = 1'b1;
    run(2, 1'b1, -1, -1);
    bub_chk = 1'b0;

    // All expectations inverted; 2-bit counter saturates; START while busy ignored.
    gen(1, 1'b0);
    for (int b = 0; b < total; b++) exp_a[b] = ~exp_a[b];
    run(1, 1'b0, -1, 6);
    last_si = si_a[total-1];

    // NUM_PAT = 0: immediate DONE, no beats, no chain clocks.
    push_exp(0);
    seen = 1'b0;
    @(posedge CLK); #1;
    START = 1'b1;
    NUM_PAT = 16'd0;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("np0_done", DONE, 1);
    seen = PAT_READY | CHAIN_CE;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      seen = seen | PAT_READY | CHAIN_CE;
    end
    chk("np0_no_ready_no_ce", seen, 0);
    chk("idle_se_hold", {SE, se2}, 2'b11);
    chk("idle_si_hold", {SI, si2}, {last_si, last_si});

    @(posedge CLK); #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
